// File: rtl/uart_rx_ctrl.sv
// Receive-side UART controller: byte FIFO with register-read pop port,
// sticky overrun, idle timeout tracking and a level/timeout/overrun interrupt.
module uart_rx_ctrl #(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 34720
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     uart_en,
   input  logic                     rec_valid,
   input  logic [7:0]               rec_dat,
   input  logic                     rd_req,
   output logic                     rd_vld,
   output logic [7:0]               rd_dat,
   output logic [$clog2(DEPTH):0]   rx_level,
   output logic                     rx_empty,
   output logic                     rx_full,
   output logic                     ovr_err,
   input  logic                     ovr_clr,
   input  logic [2:0]               rx_thresh,
   input  logic                     irq_en,
   output logic                     to_flag,
   output logic                     rx_irq
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      T_IDLE,
      T_ARMED,
      T_EXPIRED
   } t_state_e;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [LW-1:0] level_next;
   logic [15:0]   cnt_reg;
   t_state_e      state_reg;

   logic push_req;
   logic push_acc;
   logic pop_acc;
   logic overrun;
   logic lvl_hit;
   int   thr_eff;

   assign push_req = rec_valid & uart_en;
   assign pop_acc  = rd_req & ~rx_empty;
   // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
   assign push_acc = push_req & (~rx_full | pop_acc);
   assign overrun  = push_req & rx_full & ~pop_acc;

   always_comb begin
      level_next = rx_level;
      if (push_acc && !pop_acc) begin
         level_next = rx_level + LW'(1);
      end else if (pop_acc && !push_acc) begin
         level_next = rx_level - LW'(1);
      end
   end

   // Storage has no reset so it can map onto block RAM; pointers guard validity.
   always_ff @(posedge clock) begin
      if (push_acc) begin
         mem[wr_ptr_reg] <= rec_dat;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         rx_level   <= '0;
         rx_empty   <= 1'b1;
         rx_full    <= 1'b0;
         ovr_err    <= 1'b0;
         rd_vld     <= 1'b0;
         rd_dat     <= 8'h00;
      end else begin
         if (rd_req) begin
            rd_vld <= 1'b1;
            rd_dat <= pop_acc ? mem[rd_ptr_reg] : 8'h00;
         end else begin
            rd_vld <= 1'b0;
         end

         if (overrun) begin
            ovr_err <= 1'b1;
         end else if (ovr_clr) begin
            ovr_err <= 1'b0;
         end

         if (!uart_en) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            rx_level   <= '0;
            rx_empty   <= 1'b1;
            rx_full    <= 1'b0;
         end else begin
            if (push_acc) begin
               wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_acc) begin
               rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            rx_level <= level_next;
            rx_empty <= (level_next == '0);
            rx_full  <= (level_next == LVL_FULL);
         end
      end
   end

   // Arming happens on the push edge itself, so the flag rises TIMEOUT_CYC
   // cycles after the byte that made the FIFO non-empty.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg <= T_IDLE;
         cnt_reg   <= '0;
         to_flag   <= 1'b0;
      end else if (!uart_en || level_next == '0) begin
         state_reg <= T_IDLE;
         cnt_reg   <= '0;
         to_flag   <= 1'b0;
      end else begin
         case (state_reg)
            T_IDLE: begin
               state_reg <= T_ARMED;
               cnt_reg   <= '0;
            end
            T_ARMED: begin
               if (push_acc || pop_acc) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == TO_LAST) begin
                  state_reg <= T_EXPIRED;
                  to_flag   <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            T_EXPIRED: begin
               if (pop_acc) begin
                  state_reg <= T_ARMED;
                  cnt_reg   <= '0;
                  to_flag   <= 1'b0;
               end
            end
            default: begin
               state_reg <= T_IDLE;
               cnt_reg   <= '0;
               to_flag   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      thr_eff = int'(rx_thresh) + 1;
      if (thr_eff > DEPTH) begin
         thr_eff = DEPTH;
      end
      lvl_hit = (int'(rx_level) >= thr_eff);
   end

   assign rx_irq = irq_en & (lvl_hit | to_flag | ovr_err);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: FIFO ordering, overrun, timeout,
// interrupt threshold, flush and reset behaviour.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;
   localparam int TO    = 100;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       uart_en = 1'b0;
   logic       rec_valid = 1'b0;
   logic [7:0] rec_dat = 8'h00;
   logic       rd_req = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [2:0] rx_thresh = 3'd0;
   logic       irq_en = 1'b0;
   logic       rd_vld;
   logic [7:0] rd_dat;
   logic [3:0] rx_level;
   logic       rx_empty;
   logic       rx_full;
   logic       ovr_err;
   logic       to_flag;
   logic       rx_irq;

   int checks = 0;
   int failures = 0;
   logic [7:0] sb[$];

   uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .uart_en   (uart_en),
      .rec_valid (rec_valid),
      .rec_dat   (rec_dat),
      .rd_req    (rd_req),
      .rd_vld    (rd_vld),
      .rd_dat    (rd_dat),
      .rx_level  (rx_level),
      .rx_empty  (rx_empty),
      .rx_full   (rx_full),
      .ovr_err   (ovr_err),
      .ovr_clr   (ovr_clr),
      .rx_thresh (rx_thresh),
      .irq_en    (irq_en),
      .to_flag   (to_flag),
      .rx_irq    (rx_irq)
   );

   always #5 clock = ~clock;

   task tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rec_valid = 1'b1;
      rec_dat   = b;
      if (sb.size() < DEPTH) sb.push_back(b);
      tick();
      rec_valid = 1'b0;
      $display("push %02h level=%0d ovr=%0b", b, rx_level, ovr_err);
   endtask

   task automatic do_read(output logic v, output logic [7:0] d);
      rd_req = 1'b1;
      tick();
      v = rd_vld;
      d = rd_dat;
      rd_req = 1'b0;
      $display("read vld=%0b dat=%02h level=%0d", v, d, rx_level);
   endtask

   task automatic test_reset;
      resetn  = 1'b0;
      uart_en = 1'b1;
      irq_en  = 1'b1;
      repeat (3) tick();
      resetn = 1'b1;
      tick();
      checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL reset_level got %0d want 0", rx_level); end
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %0b want 1", rx_empty); end
      checks++; if (rx_full !== 1'b0) begin failures++; $display("FAIL reset_full got %0b want 0", rx_full); end
      checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL reset_ovr got %0b want 0", ovr_err); end
      checks++; if (to_flag !== 1'b0) begin failures++; $display("FAIL reset_to got %0b want 0", to_flag); end
      checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %0b want 0", rx_irq); end
      checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got %0b want 0", rd_vld); end
      checks++; if (rd_dat !== 8'h00) begin failures++; $display("FAIL reset_dat got %02h want 00", rd_dat); end
      irq_en = 1'b0;
   endtask

   task automatic test_basic;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      push_byte(8'h55);
      push_byte(8'hAA);
      push_byte(8'h0F);
      for (int i = 0; i < 3; i++) begin
         exp = sb.pop_front();
         do_read(v, d);
         checks++; if (v !== 1'b1) begin failures++; $display("FAIL basic_vld[%0d] got %0b want 1", i, v); end
         checks++; if (d !== exp) begin failures++; $display("FAIL basic_dat[%0d] got %02h want %02h", i, d, exp); end
      end
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL basic_empty got %0b want 1", rx_empty); end
      tick();
      checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL hold_vld got %0b want 0", rd_vld); end
      checks++; if (rd_dat !== 8'h0F) begin failures++; $display("FAIL hold_dat got %02h want 0f", rd_dat); end
   endtask

   task automatic test_overrun;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
      checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL ovr_full got %0b want 1", rx_full); end
      checks++; if (rx_level !== 4'd8) begin failures++; $display("FAIL ovr_level got %0d want 8", rx_level); end
      checks++; if (ovr_err !== 1'b1) begin failures++; $display("FAIL ovr_set got %0b want 1", ovr_err); end
      ovr_clr = 1'b1;
      push_byte(8'hEE);
      ovr_clr = 1'b0;
      checks++; if (ovr_err !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got %0b want 1", ovr_err); end
      for (int i = 0; i < DEPTH; i++) begin
         exp = sb.pop_front();
         do_read(v, d);
         checks++; if (d !== exp || v !== 1'b1) begin failures++; $display("FAIL ovr_read[%0d] got %02h/%0b want %02h/1", i, d, v, exp); end
      end
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL ovr_drained got %0b want 1", rx_empty); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL ovr_clear got %0b want 0", ovr_err); end
   endtask

   task automatic test_full_push_pop;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      logic [7:0] last;
      last = 8'h00;
      for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
      checks++; if (rx_full !== 1'b1) begin failures++; $display("FAIL fpp_full got %0b want 1", rx_full); end
      rec_valid = 1'b1;
      rec_dat   = 8'h77;
      rd_req    = 1'b1;
      exp = sb.pop_front();
      sb.push_back(8'h77);
      tick();
      v = rd_vld;
      d = rd_dat;
      rec_valid = 1'b0;
      rd_req    = 1'b0;
      $display("push+read 77 vld=%0b dat=%02h level=%0d", v, d, rx_level);
      checks++; if (v !== 1'b1 || d !== exp) begin failures++; $display("FAIL fpp_read got %02h/%0b want %02h/1", d, v, exp); end
      checks++; if (ovr_err !== 1'b0) begin failures++; $display("FAIL fpp_ovr got %0b want 0", ovr_err); end
      checks++; if (rx_level !== 4'd8) begin failures++; $display("FAIL fpp_level got %0d want 8", rx_level); end
      for (int i = 0; i < DEPTH; i++) begin
         exp = sb.pop_front();
         do_read(v, d);
         last = d;
         checks++; if (d !== exp) begin failures++; $display("FAIL fpp_drain[%0d] got %02h want %02h", i, d, exp); end
      end
      checks++; if (last !== 8'h77) begin failures++; $display("FAIL fpp_last got %02h want 77", last); end
   endtask

   task automatic test_timeout;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      rx_thresh = 3'd3;
      irq_en    = 1'b1;
      push_byte(8'h5A);
      repeat (TO - 1) tick();
      checks++; if (to_flag !== 1'b0) begin failures++; $display("FAIL to_early got %0b want 0", to_flag); end
      checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL to_irq_early got %0b want 0", rx_irq); end
      tick();
      checks++; if (to_flag !== 1'b1) begin failures++; $display("FAIL to_set got %0b want 1", to_flag); end
      checks++; if (rx_irq !== 1'b1) begin failures++; $display("FAIL to_irq got %0b want 1", rx_irq); end
      push_byte(8'h5B);
      checks++; if (to_flag !== 1'b1) begin failures++; $display("FAIL to_push_keeps got %0b want 1", to_flag); end
      exp = sb.pop_front();
      do_read(v, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL to_read1 got %02h want %02h", d, exp); end
      checks++; if (to_flag !== 1'b0 || rx_empty !== 1'b0) begin failures++; $display("FAIL to_rearm got to=%0b empty=%0b want 0/0", to_flag, rx_empty); end
      exp = sb.pop_front();
      do_read(v, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL to_read2 got %02h want %02h", d, exp); end
      checks++; if (to_flag !== 1'b0 || rx_irq !== 1'b0) begin failures++; $display("FAIL to_clear got to=%0b irq=%0b want 0/0", to_flag, rx_irq); end
   endtask

   task automatic test_thresh_empty;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      rx_thresh = 3'd2;
      irq_en    = 1'b1;
      push_byte(8'h61);
      push_byte(8'h62);
      checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL thr_below got %0b want 0", rx_irq); end
      push_byte(8'h63);
      checks++; if (rx_irq !== 1'b1) begin failures++; $display("FAIL thr_hit got %0b want 1", rx_irq); end
      for (int i = 0; i < 3; i++) begin
         exp = sb.pop_front();
         do_read(v, d);
         checks++; if (d !== exp) begin failures++; $display("FAIL thr_drain[%0d] got %02h want %02h", i, d, exp); end
      end
      do_read(v, d);
      checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL empty_read got %02h/%0b want 00/1", d, v); end
      checks++; if (rx_level !== 4'd0) begin failures++; $display("FAIL empty_level got %0d want 0", rx_level); end
      rec_valid = 1'b1;
      rec_dat   = 8'h3C;
      rd_req    = 1'b1;
      sb.push_back(8'h3C);
      tick();
      v = rd_vld;
      d = rd_dat;
      rec_valid = 1'b0;
      rd_req    = 1'b0;
      $display("push+read 3c on empty vld=%0b dat=%02h level=%0d", v, d, rx_level);
      checks++; if (v !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL epp_read got %02h/%0b want 00/1", d, v); end
      checks++; if (rx_level !== 4'd1) begin failures++; $display("FAIL epp_level got %0d want 1", rx_level); end
      exp = sb.pop_front();
      do_read(v, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL epp_byte got %02h want %02h", d, exp); end
      irq_en = 1'b0;
   endtask

   task automatic test_flush;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      for (int i = 0; i < 9; i++) push_byte(8'h40 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         exp = sb.pop_front();
         do_read(v, d);
         checks++; if (d !== exp) begin failures++; $display("FAIL fl_read[%0d] got %02h want %02h", i, d, exp); end
      end
      checks++; if (rx_level !== 4'd4) begin failures++; $display("FAIL fl_level4 got %0d want 4", rx_level); end
      uart_en   = 1'b0;
      rec_valid = 1'b1;
      rec_dat   = 8'hEE;
      tick();
      uart_en   = 1'b1;
      rec_valid = 1'b0;
      sb.delete();
      $display("flush level=%0d empty=%0b", rx_level, rx_empty);
      checks++; if (rx_empty !== 1'b1 || rx_level !== 4'd0) begin failures++; $display("FAIL fl_empty got %0b/%0d want 1/0", rx_empty, rx_level); end
      checks++; if (to_flag !== 1'b0) begin failures++; $display("FAIL fl_to got %0b want 0", to_flag); end
      checks++; if (ovr_err !== 1'b1) begin failures++; $display("FAIL fl_ovr_kept got %0b want 1", ovr_err); end
      push_byte(8'h31);
      exp = sb.pop_front();
      do_read(v, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL fl_after got %02h want %02h", d, exp); end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic v;
      logic [7:0] d;
      logic [7:0] exp;
      push_byte(8'hC0);
      push_byte(8'hC1);
      push_byte(8'hC2);
      #2;
      resetn = 1'b0;
      #1;
      sb.delete();
      checks++; if (rx_level !== 4'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL rst_async got %0d/%0b want 0/1", rx_level, rx_empty); end
      @(posedge clock);
      #1;
      resetn = 1'b1;
      tick();
      push_byte(8'hC3);
      exp = sb.pop_front();
      do_read(v, d);
      checks++; if (d !== exp) begin failures++; $display("FAIL rst_first got %02h want %02h", d, exp); end
      checks++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got %0b want 1", rx_empty); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_full_push_pop();
      test_timeout();
      test_thresh_empty();
      test_flush();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: receive FIFO depth in bytes, power of two, minimum 2.
REQ-002 Parameter TIMEOUT_CYC, default 34720: receive-idle timeout in clock cycles, range 2 to 65535.
REQ-003 Port clock, input, 1: single clock for all logic.
REQ-004 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-005 Port uart_en, input, 1: receiver enable; a low level flushes the block.
REQ-006 Port rec_valid, input, 1: one-cycle pulse from the receiver; rec_dat holds a valid byte.
REQ-007 Port rec_dat, input, 8: received byte.
REQ-008 Port rd_req, input, 1: one-cycle register-read pop request.
REQ-009 Port rd_vld, output, 1: read response strobe.
REQ-010 Port rd_dat, output, 8: read response data.
REQ-011 Port rx_level, output, log2(DEPTH)+1: current FIFO occupancy.
REQ-012 Port rx_empty, output, 1: FIFO empty flag.
REQ-013 Port rx_full, output, 1: FIFO full flag.
REQ-014 Port ovr_err, output, 1: sticky overrun flag.
REQ-015 Port ovr_clr, input, 1: clears ovr_err.
REQ-016 Port rx_thresh, input, 3: interrupt threshold; the effective level is rx_thresh+1, saturated at DEPTH.
REQ-017 Port irq_en, input, 1: interrupt enable.
REQ-018 Port to_flag, output, 1: receive timeout flag.
REQ-019 Port rx_irq, output, 1: interrupt output.

Function
REQ-020 The block SHALL accept a push on any cycle where rec_valid=1 and uart_en=1; rec_valid SHALL be ignored while uart_en=0.
REQ-021 A push SHALL store rec_dat at the write pointer when the FIFO is not full or a pop is accepted in the same cycle; pointers SHALL wrap modulo DEPTH.
REQ-022 A pop SHALL be accepted when rd_req=1 and rx_empty=0.
REQ-023 On the cycle after an accepted pop, the block SHALL drive rd_vld=1 and rd_dat equal to the head byte.
REQ-024 On the cycle after rd_req=1 with an empty FIFO, the block SHALL drive rd_vld=1 and rd_dat=8'h00, with no state change.
REQ-025 rd_dat SHALL hold its last value while rd_vld=0.
REQ-026 When a push and a pop occur together on a full FIFO, both SHALL complete, rx_level SHALL stay at DEPTH, and ovr_err SHALL not be set.
REQ-027 When a push and a pop occur together on an empty FIFO, the pop SHALL follow REQ-024 and the push SHALL store the byte.
REQ-028 A push on a full FIFO with no accepted pop SHALL discard the byte, leave the contents unchanged, and set ovr_err on the next cycle.
REQ-029 ovr_err SHALL clear on ovr_clr=1; if a new overrun occurs in the same cycle, set SHALL win.
REQ-030 rx_level, rx_empty and rx_full SHALL be registered and SHALL update on the cycle after each push or pop.
REQ-031 The timeout FSM SHALL have three states: T_IDLE, T_ARMED and T_EXPIRED.
REQ-032 T_IDLE SHALL go to T_ARMED when the FIFO becomes non-empty, with the 16-bit counter cleared.
REQ-033 In T_ARMED, the counter SHALL increment each cycle and SHALL clear on any push or accepted pop.
REQ-034 T_ARMED SHALL go to T_EXPIRED when the counter reaches TIMEOUT_CYC-1.
REQ-035 T_EXPIRED SHALL drive to_flag=1.
REQ-036 T_EXPIRED SHALL go to T_ARMED, with the counter cleared, on an accepted pop that leaves the FIFO non-empty.
REQ-037 T_EXPIRED SHALL go to T_IDLE on an accepted pop that leaves the FIFO empty.
REQ-038 A push while in T_EXPIRED SHALL not clear to_flag.
REQ-039 Any state SHALL go to T_IDLE when the FIFO becomes empty.
REQ-040 rx_irq SHALL equal irq_en AND (rx_level >= rx_thresh+1 OR to_flag OR ovr_err), decoded from registered state only.
REQ-041 While uart_en=0, the block SHALL synchronously empty the FIFO, clear the pointers, and return the timeout FSM to T_IDLE.
REQ-042 While uart_en=0, ovr_err SHALL be retained.

Reset
REQ-043 Reset SHALL asynchronously set: pointers=0, rx_level=0, rx_empty=1, rx_full=0, ovr_err=0, to_flag=0, rx_irq=0, rd_vld=0, rd_dat=8'h00, FSM=T_IDLE, counter=0.
REQ-044 Reset asserted mid-operation SHALL discard all stored bytes; the first push after release SHALL be read back first.

Verification
REQ-045 Scenario: push 0x55, 0xAA, 0x0F, then three rd_req -> rd_dat 0x55, 0xAA, 0x0F, each one cycle after its rd_req; rx_empty=1 at the end.
REQ-046 Scenario: DEPTH=8, push 9 bytes with no reads -> rx_full=1, ovr_err=1, and the 8 reads return the first 8 bytes; then ovr_clr -> ovr_err=0.
REQ-047 Scenario: full FIFO, simultaneous push 0x77 and rd_req -> ovr_err=0, rx_level=8, and 0x77 is read last.
REQ-048 Scenario: TIMEOUT_CYC=100, push one byte, then idle -> to_flag=1 exactly 100 cycles after the push; rx_irq=1 with irq_en=1 and rx_thresh=3; a read gives to_flag=0 and rx_irq=0.
REQ-049 Scenario: rx_thresh=2, push 3 bytes with irq_en=1 -> rx_irq rises on the cycle after the third push; rd_req on an empty FIFO -> rd_vld=1 and rd_dat=0x00.
REQ-050 Scenario: 4 bytes stored, deassert uart_en for one cycle -> rx_empty=1, rx_level=0, to_flag=0; rec_valid while uart_en=0 is ignored.
